// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_multicycle_ctrl_pkg: opcodes, state codes and datapath select codes shared with the datapath muxes.
// Build option MIPS_CTRL_BNE_EN adds BNE decoding to the controller.
package mips_multicycle_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_JMP    = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [1:0] ALUB_REGB  = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
`ifdef MIPS_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: combinational state -> datapath control word decoder.
module mips_ctrl_outdec
  import mips_multicycle_ctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ALUB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: ctrl_o.alu_src_b = ALUB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_REXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_REGB;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: ctrl_o.reg_write = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS core (state register + next-state logic).
// Define MIPS_CTRL_BNE_EN to decode BNE through the BEQ state with branch_ne raised.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  input  logic           zero,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           branch_ne,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           illegal_op,
  output logic [3:0]     state_o
);
  typedef logic [FNW-1:0] funct_t;
  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   unused_zero;
  assign unused_zero = zero;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d    = S_FETCH;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE: begin
            state_d    = BNE_EN ? S_BEQ : S_FETCH;
            illegal_op = !BNE_EN;
          end
          OP_J:         state_d = S_JMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      illegal_op = 1'b1;
        endcase
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end
`ifdef MIPS_CTRL_BNE_EN
  // the branch sense is captured at decode so the IR need not be re-examined in BEQ
  logic bne_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) bne_q <= 1'b0;
    else if (state_q == S_DECODE) bne_q <= (opcode == OP_BNE);
  assign branch_ne = (state_q == S_BEQ) && bne_q;
`else
  assign branch_ne = 1'b0;
`endif
  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign state_o       = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized instruction stream checked against a per-instruction step model.
module tb_mips_multicycle_ctrl;
`ifdef MIPS_CTRL_BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0, zero = 1'b0;
  logic [5:0] opcode = '0;
  logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;
  int n_chk = 0, n_err = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [17:0] ctrl_vec();
    return {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08} || (BNE && op == 6'h05);
  endfunction

  // expected control word for one step of an instruction, straight from the control table
  function automatic logic [17:0] exp_ctrl(input int s, input logic mr, input logic [5:0] op);
    logic pw = 0, pwc = 0, bne = 0, ia = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0, ill = 0;
    logic [1:0] asb = 0, aop = 0, psrc = 0;
    case (s)
      1:  begin mrd = 1; asb = 2'd1; irw = mr; pw = mr; end
      2:  begin asb = 2'd3; ill = !legal(op); end
      3, 11: begin asa = 1; asb = 2'd2; end
      4:  begin mrd = 1; ia = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; ia = 1; end
      7:  begin asa = 1; aop = 2'd2; end
      8:  begin rw = 1; rd = 1; end
      9:  begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; bne = BNE && op == 6'h05; end
      10: begin pw = 1; psrc = 2'd2; end
      12: rw = 1;
      default: ;
    endcase
    return {pw, pwc, bne, ia, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  // run one instruction from FETCH back to the next FETCH, stalling memory steps at random
  task automatic run_instr(input logic [5:0] op, input int stall_pct);
    int seq[$];
    bit mr;
    seq.push_back(1);
    seq.push_back(2);
    case (op)
      6'h00: begin seq.push_back(7); seq.push_back(8); end
      6'h23: begin seq.push_back(3); seq.push_back(4); seq.push_back(5); end
      6'h2B: begin seq.push_back(3); seq.push_back(6); end
      6'h04: seq.push_back(9);
      6'h05: if (BNE) seq.push_back(9);
      6'h02: seq.push_back(10);
      6'h08: begin seq.push_back(11); seq.push_back(12); end
      default: ;
    endcase
    foreach (seq[i]) begin
      do begin
        mr = ($urandom_range(99) >= stall_pct);
        @(negedge clk);
        mem_ready = mr;
        opcode = (seq[i] == 2 || seq[i] == 3) ? op : 6'($urandom);
        #1;
        chk("state", 32'(state_o), 32'(seq[i]));
        chk("ctrl", 32'(ctrl_vec()), 32'(exp_ctrl(seq[i], mr, op)));
        chk("rd_wr_excl", 32'(mem_read & mem_write), 0);
      end while (seq[i] inside {1, 4, 6} && !mr);
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3F};
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(state_o), 0);
    chk("reset_ctrl", 32'(ctrl_vec()), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_state", 32'(state_o), 0);
    chk("idle_ctrl", 32'(ctrl_vec()), 0);
    run_instr(6'h00, 0);
    run_instr(6'h23, 40);
    run_instr(6'h2B, 40);
    run_instr(6'h04, 0);
    run_instr(6'h02, 0);
    run_instr(6'h3F, 0);
    run_instr(6'h05, 0);
    run_instr(6'h08, 50);
    // reset while a store is stalled in MEMWR
    opcode = 6'h2B;
    for (int s = 1; s <= 3; s++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      chk("pre_rst_state", 32'(state_o), 32'(s));
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("memwr_state", 32'(state_o), 6);
    chk("memwr_write", 32'(mem_write), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_o), 0);
    chk("async_rst_write", 32'(mem_write), 0);
    chk("async_rst_ctrl", 32'(ctrl_vec()), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_idle", 32'(state_o), 0);
    run_instr(6'h00, 20);
    for (int n = 0; n < 200; n++)
      run_instr($urandom_range(7) == 0 ? 6'($urandom) : ops[$urandom_range(7)], 30);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
